// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target adder, destination mux and the EX/MEM pipeline register.
// Flush outranks stall; an invalid ID/EX slot is loaded as a bubble.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [1:0]  wb_ctl_in,
    input  logic [2:0]  m_ctl_in,
    input  logic        reg_dest,
    input  logic        alu_src,
    input  logic [1:0]  alu_op,
    input  logic [31:0] npc,
    input  logic [31:0] r_data_1,
    input  logic [31:0] r_data_2,
    input  logic [31:0] sign_ext,
    input  logic [4:0]  instr_2016,
    input  logic [4:0]  instr_1511,
    output logic [1:0]  wb_ctl_out,
    output logic [2:0]  m_ctl_out,
    output logic [31:0] branch_target,
    output logic        zero,
    output logic [31:0] alu_result,
    output logic [31:0] r_data_2_out,
    output logic [4:0]  write_reg,
    output logic        valid_out
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_NONE
    } alu_ctl_t;

    alu_ctl_t          alu_ctl;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   alu_val;
    logic [XLEN-1:0]   target_val;
    logic [REG_W-1:0]  dest;
    logic              bubble;

    assign op_b       = alu_src ? sign_ext : r_data_2;
    assign dest       = reg_dest ? instr_1511 : instr_2016;
    assign target_val = npc + {sign_ext[XLEN-3:0], 2'b00};
    assign bubble     = flush | (~stall & ~valid_in);

    // ALU control decode; R-type uses the funct field carried in sign_ext[5:0]
    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op)
            2'b01: alu_ctl = ALU_SUB;
            2'b10: begin
                case (sign_ext[5:0])
                    6'b100000: alu_ctl = ALU_ADD;
                    6'b100010: alu_ctl = ALU_SUB;
                    6'b100100: alu_ctl = ALU_AND;
                    6'b100101: alu_ctl = ALU_OR;
                    6'b101010: alu_ctl = ALU_SLT;
                    default:   alu_ctl = ALU_NONE;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_val = '0;
        case (alu_ctl)
            ALU_ADD: alu_val = r_data_1 + op_b;
            ALU_SUB: alu_val = r_data_1 - op_b;
            ALU_AND: alu_val = r_data_1 & op_b;
            ALU_OR:  alu_val = r_data_1 | op_b;
            ALU_SLT: alu_val = XLEN'($signed(r_data_1) < $signed(op_b));
            default: alu_val = '0;
        endcase
    end

    // EX/MEM register: reset and bubble clear everything, stall holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ctl_out    <= '0;
            m_ctl_out     <= '0;
            branch_target <= '0;
            zero          <= 1'b0;
            alu_result    <= '0;
            r_data_2_out  <= '0;
            write_reg     <= '0;
            valid_out     <= 1'b0;
        end else if (bubble) begin
            wb_ctl_out    <= '0;
            m_ctl_out     <= '0;
            branch_target <= '0;
            zero          <= 1'b0;
            alu_result    <= '0;
            r_data_2_out  <= '0;
            write_reg     <= '0;
            valid_out     <= 1'b0;
        end else if (!stall) begin
            wb_ctl_out    <= wb_ctl_in;
            m_ctl_out     <= m_ctl_in;
            branch_target <= target_val;
            zero          <= (alu_val == '0);
            alu_result    <= alu_val;
            r_data_2_out  <= r_data_2;
            write_reg     <= dest;
            valid_out     <= 1'b1;
        end
    end

endmodule
